// File: rtl/fifo_if.sv
// Producer/consumer-facing bundle of the byte FIFO: request strobes, data and status.
// No latency of its own; backpressure is signalled to the producer through full.
// The producer and consumer side uses the master modport, the FIFO uses slave.
interface fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  write;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, read, data_in,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  write, read, data_in,
        output data_out, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo.sv
// Single-clock FIFO that decouples a producer from a consumer on the same clk.
// One-cycle read latency: data_out is registered and updates on the edge that accepts the read.
// A write into a full FIFO is dropped with an overflow pulse unless a read frees a slot on the same edge.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic   clk,
    input  logic   reset,
    fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty, rd_acc, wr_acc;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign rd_acc = bus.read && !empty;
    assign wr_acc = bus.write && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = bus.write && full && !rd_acc;
        underflow_d = bus.read && empty;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy tracking makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo.sv
// Directed bench for the byte FIFO: reset, ordering, under/overflow, full read+write, async reset.
module tb_fifo;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

    fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then sample 1 ns after it.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = 8'h00;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data_in = 8'h00;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'h00);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_unf", 32'(bus.underflow), 32'd0);
        reset = 1'b1;

        // Three writes then three reads
        cyc(1'b1, 1'b0, 8'hA5); chk("w1_count", 32'(bus.count), 32'd1);
        chk("w1_empty", 32'(bus.empty), 32'd0);
        cyc(1'b1, 1'b0, 8'h3C); chk("w2_count", 32'(bus.count), 32'd2);
        cyc(1'b1, 1'b0, 8'h7E); chk("w3_count", 32'(bus.count), 32'd3);
        chk("w3_data_hold", 32'(bus.data_out), 32'h00);
        cyc(1'b0, 1'b1, 8'h00); chk("r1_data", 32'(bus.data_out), 32'hA5);
        chk("r1_count", 32'(bus.count), 32'd2);
        cyc(1'b0, 1'b1, 8'h00); chk("r2_data", 32'(bus.data_out), 32'h3C);
        chk("r2_count", 32'(bus.count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00); chk("r3_data", 32'(bus.data_out), 32'h7E);
        chk("r3_count", 32'(bus.count), 32'd0);
        chk("r3_empty", 32'(bus.empty), 32'd1);

        // Read while empty
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_pulse", 32'(bus.underflow), 32'd1);
        chk("unf_data", 32'(bus.data_out), 32'h7E);
        chk("unf_count", 32'(bus.count), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("unf_clear", 32'(bus.underflow), 32'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_full_early", 32'(bus.full), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("fill_count", 32'(bus.count), 32'd8);
        cyc(1'b1, 1'b0, 8'hFF);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd8);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data", 32'(bus.data_out), 32'(i));
            chk("drain_count", 32'(bus.count), 32'(7 - i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Read+write while full
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        chk("full2", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b1, 8'h55);
        chk("rw_full_data", 32'(bus.data_out), 32'h20);
        chk("rw_full_count", 32'(bus.count), 32'd8);
        chk("rw_full_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("wrap_data", 32'(bus.data_out), 32'(8'h20 + i));
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("wrap_55", 32'(bus.data_out), 32'h55);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Read+write while empty: write wins, no write-through
        cyc(1'b1, 1'b1, 8'h99);
        chk("rw_empty_unf", 32'(bus.underflow), 32'd1);
        chk("rw_empty_count", 32'(bus.count), 32'd1);
        chk("rw_empty_data", 32'(bus.data_out), 32'h55);
        cyc(1'b0, 1'b1, 8'h00);
        chk("rw_empty_rd", 32'(bus.data_out), 32'h99);
        chk("rw_empty_unf_clr", 32'(bus.underflow), 32'd0);

        // Async reset mid-stream
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b0, 8'hBB);
        cyc(1'b1, 1'b0, 8'hCC);
        chk("pre_arst_count", 32'(bus.count), 32'd3);
        reset = 1'b0;
        #2;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_full", 32'(bus.full), 32'd0);
        chk("arst_data", 32'(bus.data_out), 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'h11);
        chk("post_arst_count", 32'(bus.count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_arst_data", 32'(bus.data_out), 32'h11);
        chk("post_arst_empty", 32'(bus.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
